key_tone_gen: RTL and testbench

- Downstream consumer of the scan-code melody/keyboard stage.
- Takes the 8-bit key_code stream (make codes for notes 1..7 and high 1, 8'hf0 = release) and produces a 16-bit signed audio sample stream at a fixed sample rate for the audio codec serializer.
- Contains a sample-rate divider, a note latch, a phase accumulator, a triangle waveform generator and an attack/sustain/release envelope FSM.

---
 rtl/key_tone_gen_pkg.sv | 53 +++++
 rtl/key_tone_gen_env.sv | 77 +++++++
 rtl/key_tone_gen.sv | 122 ++++++++++++
 tb/tb_key_tone_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_tone_gen_pkg.sv
// key_tone_pkg: shared definitions for the key tone generator.
//   - scan-code constants for the eight note keys and the release code
//   - envelope FSM state type
//   - key_decode: scan code -> note 1..8 (0 = no key)
//   - phase_inc:  note -> 24-bit phase increment (48 kHz nominal sample rate)
package key_tone_pkg;

  localparam logic [7:0] KC_C4  = 8'h2b;
  localparam logic [7:0] KC_D4  = 8'h34;
  localparam logic [7:0] KC_E4  = 8'h33;
  localparam logic [7:0] KC_F4  = 8'h3b;
  localparam logic [7:0] KC_G4  = 8'h42;
  localparam logic [7:0] KC_A4  = 8'h4b;
  localparam logic [7:0] KC_B4  = 8'h4c;
  localparam logic [7:0] KC_C5  = 8'h52;
  localparam logic [7:0] KC_REL = 8'hf0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  function automatic logic [3:0] key_decode(input logic [7:0] code);
    case (code)
      KC_C4:   return 4'd1;
      KC_D4:   return 4'd2;
      KC_E4:   return 4'd3;
      KC_F4:   return 4'd4;
      KC_G4:   return 4'd5;
      KC_A4:   return 4'd6;
      KC_B4:   return 4'd7;
      KC_C5:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [23:0] phase_inc(input logic [3:0] note);
    case (note)
      4'd1:    return 24'd91447;
      4'd2:    return 24'd102642;
      4'd3:    return 24'd115214;
      4'd4:    return 24'd122064;
      4'd5:    return 24'd137014;
      4'd6:    return 24'd153791;
      4'd7:    return 24'd172623;
      4'd8:    return 24'd182889;
      default: return 24'd0;
    endcase
  endfunction

endpackage

// File: rtl/key_tone_gen_env.sv
// key_tone_env: attack/sustain/release envelope FSM with its 8-bit level.
// Ports:
//   clock     rising-edge clock
//   k_tr      asynchronous active-low reset
//   tick      sample-rate tick; the envelope only moves on ticks
//   press     retrigger of the held note while releasing (tick-qualified)
//   new_note  a different note was latched (tick-qualified)
//   note_off  key released while attacking or sustaining (tick-qualified)
//   env       envelope level 0..255
//   state     current FSM state
module key_tone_env
  import key_tone_pkg::*;
#(
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic       clock,
  input  logic       k_tr,
  input  logic       tick,
  input  logic       press,
  input  logic       new_note,
  input  logic       note_off,
  output logic [7:0] env,
  output env_state_t state
);

  env_state_t state_nxt;
  logic [7:0] env_nxt;
  logic [8:0] att_sum;

  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      state <= IDLE;
      env   <= '0;
    end else begin
      state <= state_nxt;
      env   <= env_nxt;
    end
  end

  // Key events change state but leave the level alone, so a note change or
  // retrigger never produces a step in amplitude.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    att_sum   = {1'b0, env} + 9'(ATTACK_STEP);
    if (tick) begin
      if (new_note || press) begin
        state_nxt = ATTACK;
      end else if (note_off) begin
        state_nxt = RELEASE;
      end else begin
        case (state)
          ATTACK: begin
            if (att_sum >= 9'd255) begin
              env_nxt   = 8'd255;
              state_nxt = SUSTAIN;
            end else begin
              env_nxt = att_sum[7:0];
            end
          end
          SUSTAIN: env_nxt = 8'd255;
          RELEASE: begin
            if (env <= 8'(RELEASE_STEP)) begin
              env_nxt   = 8'd0;
              state_nxt = IDLE;
            end else begin
              env_nxt = env - 8'(RELEASE_STEP);
            end
          end
          default: env_nxt = 8'd0;
        endcase
      end
    end
  end

endmodule

// File: rtl/key_tone_gen.sv
// key_tone_gen: turns the upstream scan-code stream into a 16-bit signed
// triangle-wave audio stream with an attack/sustain/release envelope.
// Ports:
//   clock         rising-edge clock
//   k_tr          asynchronous active-low reset
//   key_code      scan code (make codes for notes, 8'hf0 = release)
//   sample        signed audio sample, holds between strobes
//   sample_valid  one-clock strobe, sample is new this cycle
//   note_active   envelope FSM is not IDLE
//   note_index    latched note 1..8, 0 when idle
module key_tone_gen
  import key_tone_pkg::*;
#(
  parameter int SAMPLE_DIV   = 1042,
  parameter int PHASE_W      = 24,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic               clock,
  input  logic               k_tr,
  input  logic [7:0]         key_code,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               note_active,
  output logic [3:0]         note_index
);

  localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CNT_W-1:0]   div_cnt;
  logic               tick;
  logic [3:0]         d;
  logic               new_note, press, note_off, advance, fade_done;
  logic [PHASE_W-1:0] phase, inc;
  logic [7:0]         env;
  env_state_t         state;
  logic               vld_p0;

  // Triangle from the phase MSBs, scaled by the envelope. The product of an
  // 8-bit signed value and a 9-bit non-negative value always fits 16 bits.
  function automatic logic signed [15:0] wave_sample(input logic [PHASE_W-1:0] ph,
                                                     input logic [7:0] amp);
    logic [7:0]         t;
    logic signed [15:0] s8_ext;
    logic signed [15:0] amp_ext;
    t       = ph[PHASE_W-1] ? ~ph[PHASE_W-2 -: 8] : ph[PHASE_W-2 -: 8];
    s8_ext  = {{8{~t[7]}}, ~t[7], t[6:0]};
    amp_ext = {8'd0, amp};
    return s8_ext * amp_ext;
  endfunction

  assign tick = (div_cnt == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // Tick decisions, in priority order: new note, retrigger, release, advance.
  assign d         = key_decode(key_code);
  assign new_note  = tick && (d != 4'd0) && (d != note_index);
  assign press     = tick && (d != 4'd0) && (d == note_index) && (state == RELEASE);
  assign note_off  = tick && (d == 4'd0) && ((state == ATTACK) || (state == SUSTAIN));
  assign advance   = tick && !new_note && !press && !note_off;
  assign fade_done = advance && (state == RELEASE) && (env <= 8'(RELEASE_STEP));

  key_tone_env #(
    .ATTACK_STEP (ATTACK_STEP),
    .RELEASE_STEP(RELEASE_STEP)
  ) u_env (
    .clock   (clock),
    .k_tr    (k_tr),
    .tick    (tick),
    .press   (press),
    .new_note(new_note),
    .note_off(note_off),
    .env     (env),
    .state   (state)
  );

  // Stage p0: note latch, phase accumulator, tick delay
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      phase      <= '0;
      inc        <= '0;
      note_index <= '0;
      vld_p0     <= 1'b0;
    end else begin
      vld_p0 <= tick;
      if (new_note) begin
        phase      <= '0;
        inc        <= PHASE_W'(phase_inc(d));
        note_index <= d;
      end else if (fade_done) begin
        phase      <= '0;
        inc        <= '0;
        note_index <= '0;
      end else if (advance) begin
        phase <= phase + inc;
      end
    end
  end

  // Stage p1: output sample from post-tick phase and envelope
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vld_p0;
      if (vld_p0) sample <= wave_sample(phase, env);
    end
  end

  assign note_active = (state != IDLE);

endmodule

// File: tb/tb_key_tone_gen.sv
// Bench for key_tone_gen with a short sample divider: an arithmetic model of
// the note/envelope rules runs alongside the DUT and is compared every clock,
// with directed sequences pinned by hand-computed values, then random keys.
module tb_key_tone_gen;

  localparam int SD = 4;
  localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

  logic               clock;
  logic               k_tr;
  logic [7:0]         key_code;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               note_active;
  logic [3:0]         note_index;

  int checks = 0;
  int errors = 0;

  key_tone_gen #(.SAMPLE_DIV(SD)) dut (
    .clock       (clock),
    .k_tr        (k_tr),
    .key_code    (key_code),
    .sample      (sample),
    .sample_valid(sample_valid),
    .note_active (note_active),
    .note_index  (note_index)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     m_cnt, m_note, m_mode, m_env, m_pend_s, exp_sample;
  longint m_phase, m_inc;
  bit     m_pend, exp_valid;

  function automatic int m_decode(input logic [7:0] c);
    case (c)
      8'h2b: return 1;  8'h34: return 2;  8'h33: return 3;  8'h3b: return 4;
      8'h42: return 5;  8'h4b: return 6;  8'h4c: return 7;  8'h52: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic longint m_table(input int n);
    longint tbl[9] = '{0, 91447, 102642, 115214, 122064, 137014, 153791, 172623, 182889};
    return tbl[n];
  endfunction

  function automatic int m_wave(input longint ph, input int env);
    int t;
    t = int'((ph >> 15) & 255);
    if (ph >= 64'd8388608) t = 255 - t;
    return (t - 128) * env;
  endfunction

  task automatic m_tick(input logic [7:0] c);
    int dd;
    dd = m_decode(c);
    if (dd != 0 && dd != m_note) begin
      m_phase = 0; m_inc = m_table(dd); m_note = dd; m_mode = M_ATK;
    end else if (dd != 0 && dd == m_note && m_mode == M_REL) begin
      m_mode = M_ATK;
    end else if (dd == 0 && (m_mode == M_ATK || m_mode == M_SUS)) begin
      m_mode = M_REL;
    end else begin
      m_phase = (m_phase + m_inc) % 64'd16777216;
      case (m_mode)
        M_ATK: begin
          m_env = (m_env + 16 > 255) ? 255 : m_env + 16;
          if (m_env == 255) m_mode = M_SUS;
        end
        M_SUS: m_env = 255;
        M_REL: begin
          m_env = (m_env - 8 < 0) ? 0 : m_env - 8;
          if (m_env == 0) begin
            m_mode = M_IDLE; m_inc = 0; m_phase = 0; m_note = 0;
          end
        end
        default: m_env = 0;
      endcase
    end
  endtask

  always @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      m_cnt = 0; m_note = 0; m_mode = M_IDLE; m_env = 0; m_phase = 0; m_inc = 0;
      m_pend = 0; m_pend_s = 0; exp_sample = 0; exp_valid = 0;
    end else begin
      exp_valid = m_pend;
      if (m_pend) exp_sample = m_pend_s;
      m_pend = 0;
      m_cnt++;
      if (m_cnt == SD) begin
        m_cnt = 0;
        m_tick(key_code);
        m_pend   = 1;
        m_pend_s = m_wave(m_phase, m_env);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clock) begin
    #1;
    chk("cyc_sample", int'(sample), exp_sample);
    chk("cyc_valid", int'(sample_valid), int'(exp_valid));
    chk("cyc_active", int'(note_active), (m_mode != M_IDLE) ? 1 : 0);
    chk("cyc_note", int'(note_index), m_note);
  end

  // ---------------- stimulus ----------------
  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!sample_valid && n < 4 * SD + 4);
    if (!sample_valid) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) wait_strobe("strobe");
  endtask

  task automatic first_strobe_after_reset(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    k_tr = 1'b1;
    do begin
      @(posedge clock); #1; n++;
    end while (!sample_valid && n < 4 * SD);
    chk(tag, n, SD + 1);
  endtask

  logic [7:0] note_codes [8] = '{8'h2b, 8'h34, 8'h33, 8'h3b, 8'h42, 8'h4b, 8'h4c, 8'h52};

  initial begin
    int r;
    k_tr = 1'b0;
    key_code = 8'hf0;
    repeat (5) @(posedge clock);
    #1;
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(sample_valid), 0);
    chk("rst_active", int'(note_active), 0);
    chk("rst_note", int'(note_index), 0);

    first_strobe_after_reset("first_strobe");
    chk("idle_sample", int'(sample), 0);
    wait_strobe("idle");
    chk("idle_active", int'(note_active), 0);

    // Press G4 (code 42 -> note 5)
    @(negedge clock); key_code = 8'h42;
    wait_strobe("g4_1");
    chk("g4_note", int'(note_index), 5);
    chk("g4_active", int'(note_active), 1);
    chk("g4_s1", int'(sample), 0);
    wait_strobe("g4_2");
    chk("g4_s2", int'(sample), -1984);
    chk("model_env2", m_env, 16);
    strobes(15);
    chk("g4_s17", int'(sample), -15810);
    chk("model_sus", m_mode, M_SUS);

    // Release to f0 from SUSTAIN
    @(negedge clock); key_code = 8'hf0;
    strobes(32);
    chk("rel_still_active", int'(note_active), 1);
    wait_strobe("rel_end");
    chk("rel_active", int'(note_active), 0);
    chk("rel_note", int'(note_index), 0);
    chk("rel_sample", int'(sample), 0);

    // C4 to sustain, then change to C5
    @(negedge clock); key_code = 8'h2b;
    strobes(20);
    chk("c4_note", int'(note_index), 1);
    @(negedge clock); key_code = 8'h52;
    wait_strobe("c5_1");
    chk("c5_note", int'(note_index), 8);
    chk("c5_s1", int'(sample), -32640);
    wait_strobe("c5_2");
    chk("c5_s2", int'(sample), -31365);
    strobes(3);

    // Unmapped code releases, re-press of the same note retriggers
    @(negedge clock); key_code = 8'h2b;
    strobes(3);
    @(negedge clock); key_code = 8'h1c;
    strobes(5);
    chk("unmapped_active", int'(note_active), 1);
    chk("model_rel_env", m_env, 223);
    @(negedge clock); key_code = 8'h2b;
    wait_strobe("retrig");
    chk("retrig_note", int'(note_index), 1);
    chk("model_retrig", m_mode, M_ATK);
    strobes(4);

    // Random keys, changed at arbitrary clocks (ignored between ticks)
    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(1, 160)) @(negedge clock);
      r = $urandom_range(0, 12);
      if (r < 8) key_code = note_codes[r];
      else if (r < 10) key_code = 8'hf0;
      else if (r == 10) key_code = 8'h1c;
      else key_code = 8'($urandom);
    end

    // Asynchronous reset in the middle of an attack
    @(negedge clock); k_tr = 1'b0;
    repeat (2) @(negedge clock);
    key_code = 8'hf0;
    first_strobe_after_reset("restart_strobe");
    @(negedge clock); key_code = 8'h42;
    strobes(3);
    @(posedge clock); #3;
    k_tr = 1'b0;
    #1;
    chk("async_sample", int'(sample), 0);
    chk("async_valid", int'(sample_valid), 0);
    chk("async_active", int'(note_active), 0);
    chk("async_note", int'(note_index), 0);
    repeat (3) @(negedge clock);
    first_strobe_after_reset("post_async_strobe");
    strobes(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
